// File: rtl/input_tile_mac.sv
// Fixed-point tile MAC: multiplies TN_P lanes per beat and accumulates over num_tiles beats into one saturated result per job.
// Latency: result valid 3 cycles after the last accepted beat; full-throughput beat acceptance in ACCUM.
// Backpressure: in_ready_o is high only in ACCUM; the result is held stable until out_ready_i. Optional ReLU: INPUT_TILE_MAC_RELU_EN.
module input_tile_mac #(
    parameter int TN_P             = 4,
    parameter int DATA_WIDTH_P     = 16,
    parameter int FRAC_BITS_P      = 8,
    parameter int ACC_WIDTH_P      = 40,
    parameter int TILE_CNT_WIDTH_P = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   start_i,
    input  logic [TILE_CNT_WIDTH_P-1:0]            num_tiles_i,
    input  logic [DATA_WIDTH_P-1:0]                fm_init_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [TN_P-1:0][DATA_WIDTH_P-1:0]      fm_i,
    input  logic [TN_P-1:0][DATA_WIDTH_P-1:0]      weights_i,
    input  logic [TN_P-1:0]                        lane_en_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [DATA_WIDTH_P-1:0]                fm_o,
    output logic                                   sat_o,
    output logic                                   busy_o
);

    localparam int PW = 2 * DATA_WIDTH_P;

    localparam logic signed [ACC_WIDTH_P-1:0] RES_MAX =
        {{(ACC_WIDTH_P-DATA_WIDTH_P+1){1'b0}}, {(DATA_WIDTH_P-1){1'b1}}};
    localparam logic signed [ACC_WIDTH_P-1:0] RES_MIN =
        {{(ACC_WIDTH_P-DATA_WIDTH_P+1){1'b1}}, {(DATA_WIDTH_P-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [TILE_CNT_WIDTH_P-1:0]    num_tiles_q, num_tiles_d;
    logic [TILE_CNT_WIDTH_P-1:0]    beat_cnt_q, beat_cnt_d;
    logic signed [ACC_WIDTH_P-1:0]  acc_q, acc_d;
    logic [TN_P-1:0][PW-1:0]        prod_q, prod_d;
    logic                           prod_vld_q, prod_vld_d;
    logic signed [ACC_WIDTH_P-1:0]  sum_q, sum_d;
    logic                           sum_vld_q, sum_vld_d;
    logic                           out_valid_q, out_valid_d;
    logic [DATA_WIDTH_P-1:0]        fm_res_q, fm_res_d;
    logic                           sat_q, sat_d;

    logic                           beat_acc;
    logic signed [ACC_WIDTH_P-1:0]  init_ext;
    logic signed [ACC_WIDTH_P-1:0]  res_shift;
    logic [DATA_WIDTH_P-1:0]        res_fm;
    logic                           res_sat;

    assign in_ready_o  = (state_q == ACCUM);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign fm_o        = fm_res_q;
    assign sat_o       = sat_q;

    assign beat_acc = (state_q == ACCUM) && in_valid_i;
    assign init_ext = {{(ACC_WIDTH_P-DATA_WIDTH_P){fm_init_i[DATA_WIDTH_P-1]}}, fm_init_i};

    // Stage 1: masked lane products; disabled lanes contribute zero.
    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = beat_acc;
        if (beat_acc) begin
            for (int i = 0; i < TN_P; i++) begin
                if (lane_en_i[i]) begin
                    prod_d[i] = $signed(fm_i[i]) * $signed(weights_i[i]);
                end else begin
                    prod_d[i] = '0;
                end
            end
        end
    end

    // Stage 2: sign-extended lane sum.
    always_comb begin
        sum_d     = sum_q;
        sum_vld_d = prod_vld_q;
        if (prod_vld_q) begin
            sum_d = '0;
            for (int i = 0; i < TN_P; i++) begin
                sum_d = sum_d + {{(ACC_WIDTH_P-PW){prod_q[i][PW-1]}}, prod_q[i]};
            end
        end
    end

    // Result is computed from the next accumulator value so it is registered
    // in the same edge as the final accumulate.
    always_comb begin
        res_shift = acc_d >>> FRAC_BITS_P;
        res_fm    = res_shift[DATA_WIDTH_P-1:0];
        res_sat   = 1'b0;
        if (res_shift > RES_MAX) begin
            res_fm  = {1'b0, {(DATA_WIDTH_P-1){1'b1}}};
            res_sat = 1'b1;
        end else if (res_shift < RES_MIN) begin
            res_fm  = {1'b1, {(DATA_WIDTH_P-1){1'b0}}};
            res_sat = 1'b1;
        end
`ifdef INPUT_TILE_MAC_RELU_EN
        if (res_shift[ACC_WIDTH_P-1]) begin
            res_fm  = '0;
            res_sat = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        fm_res_d    = fm_res_q;
        sat_d       = sat_q;

        if (sum_vld_q) begin
            acc_d = acc_q + sum_q;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    num_tiles_d = num_tiles_i;
                    beat_cnt_d  = '0;
                    acc_d       = init_ext <<< FRAC_BITS_P;
                    state_d     = (num_tiles_i == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + TILE_CNT_WIDTH_P'(1);
                    if (beat_cnt_q == num_tiles_q - TILE_CNT_WIDTH_P'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Once stage 1 is empty, the last sum folds into acc this cycle.
                if (!prod_vld_q) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == OUT) && (state_q != OUT)) begin
            out_valid_d = 1'b1;
            fm_res_d    = res_fm;
            sat_d       = res_sat;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            num_tiles_q <= '0;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            sum_q       <= '0;
            sum_vld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            fm_res_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            sum_q       <= sum_d;
            sum_vld_q   <= sum_vld_d;
            out_valid_q <= out_valid_d;
            fm_res_q    <= fm_res_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_input_tile_mac.sv
// Scoreboard bench for input_tile_mac: directed jobs push expected results; a monitor checks every presented result.
module tb_input_tile_mac;
    localparam int TN = 4;
    localparam int DW = 16;
    localparam int TCW = 8;

    typedef struct packed {
        logic [DW-1:0] fm;
        logic          sat;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   reset_n_i;
    logic                   start_i;
    logic [TCW-1:0]         num_tiles_i;
    logic [DW-1:0]          fm_init_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [TN-1:0][DW-1:0]  fm_i;
    logic [TN-1:0][DW-1:0]  weights_i;
    logic [TN-1:0]          lane_en_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DW-1:0]          fm_o;
    logic                   sat_o;
    logic                   busy_o;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;

    always #5 clk_i = ~clk_i;

    input_tile_mac dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .start_i     (start_i),
        .num_tiles_i (num_tiles_i),
        .fm_init_i   (fm_init_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fm_i        (fm_i),
        .weights_i   (weights_i),
        .lane_en_i   (lane_en_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .fm_o        (fm_o),
        .sat_o       (sat_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: every presented result (stalled or not) is compared with the head of the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (reset_n_i && out_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=0x%0h required=none", fm_o);
            end else begin
                e = sb_q[0];
                check("result_fm", {16'h0, fm_o}, {16'h0, e.fm});
                check("result_sat", {31'h0, sat_o}, {31'h0, e.sat});
                if (out_ready_i) e = sb_q.pop_front();
            end
        end
    end

    always @(negedge clk_i) begin
        if (in_valid_i && in_ready_o) acc_cnt++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [TN-1:0][DW-1:0] rep(input logic [DW-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic start_job(input logic [TCW-1:0] nt, input logic [DW-1:0] init);
        start_i     = 1'b1;
        num_tiles_i = nt;
        fm_init_i   = init;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic send_beat(input logic [TN-1:0][DW-1:0] f, input logic [TN-1:0][DW-1:0] w,
                             input logic [TN-1:0] en);
        int n;
        fm_i       = f;
        weights_i  = w;
        lane_en_i  = en;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
        end
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy_o || sb_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL job_timeout actual=busy required=idle");
        end
    endtask

    task automatic push(input logic [DW-1:0] fm, input logic sat);
        exp_t e;
        e.fm  = fm;
        e.sat = sat;
        sb_q.push_back(e);
    endtask

    initial begin
        int n;
        reset_n_i   = 1'b0;
        start_i     = 1'b0;
        num_tiles_i = '0;
        fm_init_i   = '0;
        in_valid_i  = 1'b0;
        fm_i        = '0;
        weights_i   = '0;
        lane_en_i   = '0;
        out_ready_i = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", {31'h0, in_ready_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
        check("rst_fm", {16'h0, fm_o}, 32'h0);
        check("rst_sat", {31'h0, sat_o}, 32'h0);
        reset_n_i = 1'b1;
        tick();

        // Single tile with result latency check.
        push(16'h0A80, 1'b0);
        start_job(8'd1, 16'h0080);
        send_beat({16'h0400, 16'h0300, 16'h0200, 16'h0100}, rep(16'h0100), 4'hF);
        check("lat_t1", {31'h0, out_valid_o}, 32'h0);
        tick();
        check("lat_t2", {31'h0, out_valid_o}, 32'h0);
        tick();
        check("lat_t3", {31'h0, out_valid_o}, 32'h1);
        wait_done();

        // Three back-to-back tiles with valid held beyond the job.
        push(16'h0300, 1'b0);
        start_job(8'd3, 16'h0000);
        acc_cnt    = 0;
        fm_i       = rep(16'h0040);
        weights_i  = rep(16'h0100);
        lane_en_i  = 4'hF;
        in_valid_i = 1'b1;
        repeat (6) tick();
        in_valid_i = 1'b0;
        check("accept_count", acc_cnt, 32'd3);
        wait_done();

        // Partial last tile.
        push(16'h0C00, 1'b0);
        start_job(8'd2, 16'h0000);
        send_beat(rep(16'h0200), rep(16'h0100), 4'hF);
        send_beat(rep(16'h0200), rep(16'h0100), 4'b0011);
        wait_done();

        // Positive and negative saturation.
        push(16'h7FFF, 1'b1);
        start_job(8'd1, 16'h0000);
        send_beat(rep(16'h6400), rep(16'h6400), 4'hF);
        wait_done();
`ifdef INPUT_TILE_MAC_RELU_EN
        push(16'h0000, 1'b0);
`else
        push(16'h8000, 1'b1);
`endif
        start_job(8'd1, 16'h0000);
        send_beat(rep(16'h6400), rep(16'h9C00), 4'hF);
        wait_done();

        // Valid while idle is ignored; gaps between beats; mixed-sign lanes.
        acc_cnt    = 0;
        in_valid_i = 1'b1;
        repeat (2) tick();
        in_valid_i = 1'b0;
        check("idle_no_accept", acc_cnt, 32'd0);
        push(16'h0500, 1'b0);
        start_job(8'd2, 16'h0100);
        repeat (3) tick();
        send_beat({16'h0080, 16'h0200, 16'hFF00, 16'h0100},
                  {16'h0200, 16'h0080, 16'h0100, 16'h0100}, 4'hF);
        repeat (4) tick();
        send_beat({16'h0080, 16'h0200, 16'hFF00, 16'h0100},
                  {16'h0200, 16'h0080, 16'h0100, 16'h0100}, 4'hF);
        wait_done();

        // Arithmetic shift truncates toward minus infinity.
`ifdef INPUT_TILE_MAC_RELU_EN
        push(16'h0000, 1'b0);
`else
        push(16'hFFFF, 1'b0);
`endif
        start_job(8'd1, 16'h0000);
        send_beat(rep(16'hFFFF), rep(16'h0080), 4'b0001);
        wait_done();

        // Zero-tile job returns the initial value.
`ifdef INPUT_TILE_MAC_RELU_EN
        push(16'h0000, 1'b0);
`else
        push(16'hFE80, 1'b0);
`endif
        start_job(8'd0, 16'hFE80);
        wait_done();

        // Output stall for 5 cycles with a start pulse that must be ignored.
        push(16'h0400, 1'b0);
        out_ready_i = 1'b0;
        start_job(8'd1, 16'h0000);
        send_beat(rep(16'h0100), rep(16'h0100), 4'hF);
        n = 0;
        while (!out_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("stall_out_valid", {31'h0, out_valid_o}, 32'h1);
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        check("stall_busy", {31'h0, busy_o}, 32'h1);
        out_ready_i = 1'b1;
        tick();
        repeat (3) tick();
        check("start_ignored_busy", {31'h0, busy_o}, 32'h0);
        check("start_ignored_valid", {31'h0, out_valid_o}, 32'h0);

        // Reset in the middle of a 3-tile job.
        start_job(8'd3, 16'h0000);
        send_beat(rep(16'h0100), rep(16'h0100), 4'hF);
        tick();
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy_o}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready_o}, 32'h0);
        check("mid_rst_out_valid", {31'h0, out_valid_o}, 32'h0);
        check("mid_rst_fm", {16'h0, fm_o}, 32'h0);
        check("mid_rst_sat", {31'h0, sat_o}, 32'h0);
        tick();
        reset_n_i = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", {31'h0, out_valid_o}, 32'h0);
        push(16'h0A80, 1'b0);
        start_job(8'd1, 16'h0080);
        send_beat({16'h0400, 16'h0300, 16'h0200, 16'h0100}, rep(16'h0100), 4'hF);
        wait_done();

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
